tdm_demux_4ch: RTL and testbench

//   Receive end of the team's TDM link: de-serialises a 1-bit time-division stream built by 4:1 mux selection back into
//   NUM_CH parallel words. Frame-synchronised via frame_sync; one bit accepted per in_valid cycle; whole frame emitted
//   as one registered word set with a single-cycle out_valid. Sits between the link pin sampler and per-channel consumers.

---
 rtl/tdm_pkg.sv | 26 ++
 rtl/tdm_slot_counter.sv | 61 ++++++
 rtl/tdm_demux_4ch.sv | 170 +++++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM receive demultiplexer.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds one even-parity bit per slot).
package tdm_pkg;

`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        HUNT,
        LOCK
    } state_e;

    // Bits carried per slot: data word plus optional trailing parity bit.
    function automatic int unsigned slot_len(input int unsigned word_w, input bit parity_en);
        return word_w + (parity_en ? 32'd1 : 32'd0);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-within-slot and slot-within-frame position counters for the TDM demux.
// load_i restarts the frame at position 0; combined with en_i the loaded bit is
// counted, so the counters then point at frame bit 1.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 8,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned BIT_W    = 3,
    parameter int unsigned SLOT_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    output logic [BIT_W-1:0]  bit_cnt_o,
    output logic [SLOT_W-1:0] slot_cnt_o,
    output logic              frame_end_o
);

    localparam logic [BIT_W-1:0]  BitLast  = BIT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(NUM_CH - 1);

    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_base;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d, slot_base;
    logic              last_bit, last_slot;

    // Next position: optional restart, then advance on an accepted bit.
    always_comb begin
        bit_base    = load_i ? '0 : bit_cnt_q;
        slot_base   = load_i ? '0 : slot_cnt_q;
        bit_cnt_d   = bit_base;
        slot_cnt_d  = slot_base;
        last_bit    = (bit_base == BitLast);
        last_slot   = (slot_base == SlotLast);
        frame_end_o = en_i && last_bit && last_slot;
        if (en_i) begin
            if (last_bit) begin
                bit_cnt_d  = '0;
                slot_cnt_d = last_slot ? '0 : slot_base + 1'b1;
            end else begin
                bit_cnt_d = bit_base + 1'b1;
            end
        end
    end

    // Position registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign bit_cnt_o  = bit_cnt_q;
    assign slot_cnt_o = slot_cnt_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// TDM receive demultiplexer: frame-synchronised serial-to-parallel conversion of
// NUM_CH slots of WORD_W bits (MSB first), emitting a whole frame per out_valid.
// Optional feature macro: TDM_DEMUX_PARITY_EN (per-slot even parity, parity_err port).
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WORD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_bit,
    input  logic                     in_valid,
    input  logic                     frame_sync,
    output logic [NUM_CH*WORD_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic [NUM_CH-1:0]        parity_err,
`endif
    output logic                     sync_err
);

    localparam int unsigned SLOT_LEN = slot_len(WORD_W, PARITY_EN);
    localparam int unsigned BIT_W    = cnt_w(SLOT_LEN);
    localparam int unsigned SLOT_W   = cnt_w(NUM_CH);

    state_e                   state_q, state_d;
    logic [SLOT_LEN-1:0]      shadow_q [NUM_CH];
    logic [SLOT_LEN-1:0]      shadow_d [NUM_CH];
    logic [NUM_CH*WORD_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q;
    logic                     frame_end_q, frame_end_d;
    logic                     sync_err_q, sync_err_d;

    logic                     cnt_en, cnt_load, cnt_frame_end;
    logic [BIT_W-1:0]         bit_cnt;
    logic [SLOT_W-1:0]        slot_cnt;
    logic                     shift_en;
    logic [SLOT_W-1:0]        shift_sel;
    logic                     frame_pos0;

    tdm_slot_counter #(
        .SLOT_LEN (SLOT_LEN),
        .NUM_CH   (NUM_CH),
        .BIT_W    (BIT_W),
        .SLOT_W   (SLOT_W)
    ) u_counter (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (cnt_en),
        .load_i      (cnt_load),
        .bit_cnt_o   (bit_cnt),
        .slot_cnt_o  (slot_cnt),
        .frame_end_o (cnt_frame_end)
    );

    assign frame_pos0 = (bit_cnt == '0) && (slot_cnt == '0);

    // FSM next state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        shift_en    = 1'b0;
        shift_sel   = slot_cnt;
        sync_err_d  = 1'b0;
        frame_end_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (in_valid && frame_sync) begin
                    state_d   = LOCK;
                    cnt_en    = 1'b1;
                    cnt_load  = 1'b1;
                    shift_en  = 1'b1;
                    shift_sel = '0;
                end
            end
            LOCK: begin
                if (in_valid) begin
                    cnt_en   = 1'b1;
                    shift_en = 1'b1;
                    if (frame_sync && !frame_pos0) begin
                        // Misplaced sync: drop the partial frame and restart on this bit.
                        cnt_load   = 1'b1;
                        shift_sel  = '0;
                        sync_err_d = 1'b1;
                    end else begin
                        frame_end_d = cnt_frame_end;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Shift the accepted bit into the addressed slot's shadow register.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            shadow_d[ch] = shadow_q[ch];
        end
        if (shift_en) begin
            shadow_d[shift_sel] = (shadow_q[shift_sel] << 1) | SLOT_LEN'(in_bit);
        end
    end

    // Transfer completed shadows to the output word the cycle after the last bit.
    always_comb begin
        out_data_d = out_data_q;
        if (frame_end_q) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                out_data_d[ch*WORD_W +: WORD_W] = shadow_q[ch][SLOT_LEN-1 -: WORD_W];
            end
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shadow_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= frame_end_q;
            frame_end_q <= frame_end_d;
            sync_err_q  <= sync_err_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shadow_q[ch] <= shadow_d[ch];
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic [NUM_CH-1:0] parity_err_q, parity_err_d;

    // Even parity check per slot over data plus trailing parity bit.
    always_comb begin
        parity_err_d = parity_err_q;
        if (frame_end_q) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                parity_err_d[ch] = ^shadow_q[ch];
            end
        end
    end

    // Parity flags update together with out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= '0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == LOCK);
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios plus random serial
// traffic, all compared every cycle against a frame-position reference model.
module tb_tdm_demux_4ch;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT = WORD_W + 1;
`else
    localparam int SLOT = WORD_W;
`endif
    localparam int FRAME = NUM_CH * SLOT;
    localparam int DW    = NUM_CH * WORD_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          locked;
    logic          sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic [NUM_CH-1:0] parity_err;
`endif

    tdm_demux_4ch #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .parity_err (parity_err),
`endif
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: lock flag, position inside frame, received bits.
    bit                m_locked;
    int                m_pos;
    logic [FRAME-1:0]  m_bits;
    bit                pend_valid;
    logic [DW-1:0]     pend_data;
    logic [NUM_CH-1:0] pend_par;
    logic [DW-1:0]     held_data;
    logic [NUM_CH-1:0] held_par;
    int                cyc;
    int                vcount;
    int                last_v_cyc;
    int                prev_v_cyc;
    int                serr_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked   = 1'b0;
        m_pos      = 0;
        m_bits     = '0;
        pend_valid = 1'b0;
        held_data  = '0;
        held_par   = '0;
    endfunction

    // Reassemble the per-channel words and parity flags from a complete frame.
    function automatic void model_frame_done();
        logic [DW-1:0]     d;
        logic [NUM_CH-1:0] par;
        d   = '0;
        par = '0;
        for (int p = 0; p < FRAME; p++) begin
            int s = p / SLOT;
            int w = p % SLOT;
            if (w < WORD_W) d[s*WORD_W + WORD_W-1-w] = m_bits[p];
            par[s] = par[s] ^ m_bits[p];
        end
        pend_valid = 1'b1;
        pend_data  = d;
        pend_par   = par;
    endfunction

    function automatic void model_accept(input logic b);
        m_bits[m_pos] = b;
        m_pos++;
        if (m_pos == FRAME) begin
            m_pos = 0;
            model_frame_done();
        end
    endfunction

    // One clock: drive inputs, advance model, compare every output.
    task automatic step(input logic v, input logic b, input logic s);
        bit exp_valid;
        bit exp_serr;
        in_valid   = v;
        in_bit     = b;
        frame_sync = s;
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = pend_valid;
        if (pend_valid) begin
            held_data = pend_data;
            held_par  = pend_par;
        end
        pend_valid = 1'b0;
        exp_serr   = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_pos    = 0;
                    model_accept(b);
                end
            end else begin
                if (s && m_pos != 0) begin
                    exp_serr = 1'b1;
                    m_pos    = 0;
                end
                model_accept(b);
            end
        end
        if (out_valid === 1'b1) begin
            prev_v_cyc = last_v_cyc;
            last_v_cyc = cyc;
            vcount++;
        end
        if (sync_err === 1'b1) serr_count++;
        check("locked", 64'(locked), 64'(m_locked));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("sync_err", 64'(sync_err), 64'(exp_serr));
        check("out_data", 64'(out_data), 64'(held_data));
`ifdef TDM_DEMUX_PARITY_EN
        check("parity_err", 64'(parity_err), 64'(held_par));
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            in_valid   = 1'($urandom);
            in_bit     = 1'($urandom);
            frame_sync = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        model_reset();
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        rst_n = 1'b1;
    endtask

    // Serialise one frame; optional sync on bit 0, random stalls, parity corruption.
    task automatic send_frame(input logic [DW-1:0] words, input bit sync,
                              input int stalls_per_slot, input logic [NUM_CH-1:0] par_flip);
        for (int s = 0; s < NUM_CH; s++) begin
            logic [WORD_W-1:0] w;
            int                pos [3];
            w = words[s*WORD_W +: WORD_W];
            for (int k = 0; k < 3; k++) pos[k] = (k < stalls_per_slot) ? $urandom_range(SLOT-1) : -1;
            for (int j = 0; j < SLOT; j++) begin
                logic b;
                for (int k = 0; k < 3; k++) begin
                    if (pos[k] == j) step(1'b0, 1'($urandom), 1'($urandom));
                end
                b = (j < WORD_W) ? w[WORD_W-1-j] : ((^w) ^ par_flip[s]);
                step(1'b1, b, sync && s == 0 && j == 0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
    endtask

    localparam logic [DW-1:0] FRAME1 = 32'h01FF3CA5;

    initial begin
        logic [DW-1:0] fa;
        logic [DW-1:0] fb;
        int            v0;
        cyc        = 0;
        vcount     = 0;
        last_v_cyc = 0;
        prev_v_cyc = 0;
        serr_count = 0;
        model_reset();

        // 1: reset, then one synchronised frame.
        do_reset(3);
        v0 = vcount;
        send_frame(FRAME1, 1'b1, 0, '0);
        idle(2);
        check("t1_data", 64'(out_data), 64'(FRAME1));
        check("t1_pulses", 64'(vcount - v0), 64'd1);
        check("t1_locked", 64'(locked), 64'd1);

        // 2: bits without sync stay unlocked, then a sync locks.
        do_reset(2);
        v0 = vcount;
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 1'b0);
        check("t2_no_pulse", 64'(vcount - v0), 64'd0);
        fa = DW'($urandom);
        send_frame(fa, 1'b1, 0, '0);
        idle(2);
        check("t2_data", 64'(out_data), 64'(fa));

        // 3: same frame with three stall cycles per slot.
        v0 = vcount;
        send_frame(FRAME1, 1'b1, 3, '0);
        idle(2);
        check("t3_data", 64'(out_data), 64'(FRAME1));
        check("t3_pulses", 64'(vcount - v0), 64'd1);

        // 4: sync at frame bit 13 while locked.
        v0         = vcount;
        serr_count = 0;
        for (int i = 0; i < 13; i++) step(1'b1, 1'($urandom), 1'b0);
        fb = DW'($urandom);
        send_frame(fb, 1'b1, 0, '0);
        idle(2);
        check("t4_serr", 64'(serr_count), 64'd1);
        check("t4_pulses", 64'(vcount - v0), 64'd1);
        check("t4_data", 64'(out_data), 64'(fb));

        // 5: two frames back to back, second without sync.
        fa = DW'($urandom);
        fb = DW'($urandom);
        v0 = vcount;
        send_frame(fa, 1'b1, 0, '0);
        send_frame(fb, 1'b0, 0, '0);
        idle(2);
        check("t5_pulses", 64'(vcount - v0), 64'd2);
        check("t5_spacing", 64'(last_v_cyc - prev_v_cyc), 64'(FRAME));
        check("t5_data", 64'(out_data), 64'(fb));

        // 6: reset mid-frame, then a fresh frame.
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), i == 0);
        do_reset(1);
        v0 = vcount;
        idle(3);
        check("t6_no_stale", 64'(vcount - v0), 64'd0);
        fa = DW'($urandom);
        send_frame(fa, 1'b1, 1, 4'b0100);
        idle(2);
        check("t6_data", 64'(out_data), 64'(fa));
`ifdef TDM_DEMUX_PARITY_EN
        check("t6_parity", 64'(parity_err), 64'h4);
`endif

        // Random traffic: stalls, sparse syncs, resyncs.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(29) == 0));
        end
        for (int i = 0; i < 6; i++) begin
            send_frame(DW'($urandom), 1'($urandom), $urandom_range(3), NUM_CH'($urandom));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
